// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory for a small core testbench/SoC. Loads are
//   combinational (zero wait states); stores commit on the rising edge.
//
//   Optional feature macro: DMEM_MMIO_EN
//     undefined : the whole byte-address space maps to RAM, o_tohost and
//                 o_done are tied to 0, no counters exist.
//     defined   : the top 16 bytes (addr[AW-1:4] all ones) form an MMIO window
//                 that shadows the RAM words beneath it:
//                   offset 0x0 CYCLE  (RO, free-running clock count)
//                   offset 0x4 STCNT  (RO, accepted store count)
//                   offset 0x8 TOHOST (RW, drives o_tohost, sets o_done)
//                   offset 0xC STATUS (read {0, o_done}; write bit0=1 clears)
//
//   Ports
//     i_clk        : clock, all state on rising edge
//     i_rst_n      : asynchronous active-low reset (RAM is not cleared)
//     i_dmem_we    : store request this cycle
//     i_dmem_addr  : byte address, bits [1:0] ignored
//     i_dmem_wdata : store data
//     o_dmem_rdata : load data, combinational from i_dmem_addr
//     o_tohost     : last value written to TOHOST
//     o_done       : sticky, set by any TOHOST write
module data_mem_responder #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    output logic [P_DATA_WIDTH-1:0]      o_tohost,
    output logic                         o_done
);

    localparam int LP_IDX_W = P_DMEM_ADDR_WIDTH - 2;
    localparam int LP_DEPTH = 2 ** LP_IDX_W;

    logic [P_DATA_WIDTH-1:0] ram [LP_DEPTH];
    logic [LP_IDX_W-1:0]     word_idx;
    logic                    store_ok;
    logic                    unused_addr_lsbs;

    assign word_idx         = i_dmem_addr[P_DMEM_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^i_dmem_addr[1:0];
    // Gating with i_rst_n drops any store presented while reset is held.
    assign store_ok         = i_dmem_we & i_rst_n;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!$isunknown(i_dmem_we));
        end
    end

`ifdef DMEM_MMIO_EN
    localparam logic [P_DATA_WIDTH-1:0] LP_ONE = 1;

    logic                    is_mmio;
    logic [1:0]              mmio_off;
    logic [P_DATA_WIDTH-1:0] cycle_cnt;
    logic [P_DATA_WIDTH-1:0] store_cnt;
    logic [P_DATA_WIDTH-1:0] tohost_q;
    logic                    done_q;

    assign is_mmio  = &i_dmem_addr[P_DMEM_ADDR_WIDTH-1:4];
    assign mmio_off = i_dmem_addr[3:2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            tohost_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + LP_ONE;
            if (i_dmem_we) begin
                store_cnt <= store_cnt + LP_ONE;
                if (is_mmio) begin
                    case (mmio_off)
                        2'd2: begin
                            tohost_q <= i_dmem_wdata;
                            done_q   <= 1'b1;
                        end
                        2'd3: begin
                            if (i_dmem_wdata[0]) begin
                                done_q <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (store_ok && !is_mmio) begin
            ram[word_idx] <= i_dmem_wdata;
        end
    end

    always_comb begin
        o_dmem_rdata = ram[word_idx];
        if (is_mmio) begin
            case (mmio_off)
                2'd0:    o_dmem_rdata = cycle_cnt;
                2'd1:    o_dmem_rdata = store_cnt;
                2'd2:    o_dmem_rdata = tohost_q;
                default: o_dmem_rdata = {{(P_DATA_WIDTH-1){1'b0}}, done_q};
            endcase
        end
    end

    assign o_tohost = tohost_q;
    assign o_done   = done_q;
`else
    always_ff @(posedge i_clk) begin
        if (store_ok) begin
            ram[word_idx] <= i_dmem_wdata;
        end
    end

    assign o_dmem_rdata = ram[word_idx];
    assign o_tohost     = '0;
    assign o_done       = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter P_DMEM_ADDR_WIDTH, default 11, byte-address width; RAM depth = 2^(P_DMEM_ADDR_WIDTH-2) words.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_dmem_we  input  1  store request for the current cycle.
REQ-006 SHALL have port i_dmem_addr  input  P_DMEM_ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-007 SHALL have port i_dmem_wdata  input  P_DATA_WIDTH  store data.
REQ-008 SHALL have port o_dmem_rdata  output  P_DATA_WIDTH  load data.
REQ-009 SHALL have port o_tohost  output  P_DATA_WIDTH  last value written to TOHOST.
REQ-010 SHALL have port o_done  output  1  sticky flag, set by any TOHOST write.

Function
REQ-011 SHALL return o_dmem_rdata combinationally from i_dmem_addr in the same cycle, with zero wait states.
REQ-012 SHALL commit a store to the addressed word on the rising edge when i_dmem_we=1; a same-cycle read of that word returns the old value.
REQ-013 SHALL define MMIO window as addr[P_DMEM_ADDR_WIDTH-1:4] all ones; default map 0x7F0 CYCLE, 0x7F4 STCNT, 0x7F8 TOHOST, 0x7FC STATUS.
REQ-014 SHALL increment CYCLE every clock, wrapping 0xFFFFFFFF->0; read-only; writes ignored.
REQ-015 SHALL increment STCNT on every accepted store, RAM or MMIO, wrapping at 2^32; read-only.
REQ-016 SHALL load TOHOST from i_dmem_wdata on write, drive it on o_tohost, and set o_done in the same edge.
REQ-017 SHALL read STATUS as {31'b0, o_done}; writing STATUS with wdata[0]=1 clears o_done.
REQ-018 SHALL give set priority when a TOHOST write and a clear occur together (impossible in one cycle; single port); a TOHOST write while o_done=1 updates o_tohost and keeps o_done=1.
REQ-019 SHALL return 0 on reads of unmapped MMIO offsets and ignore writes to them.
REQ-020 SHALL never let MMIO stores modify the RAM array; RAM words aliased under the MMIO window are unreachable.
REQ-021 SHALL treat X/undefined i_dmem_we as no store in simulation assertions (flagged error).

Reset
REQ-022 SHALL on i_rst_n=0 immediately clear CYCLE, STCNT, o_tohost, and o_done to 0, independent of i_clk.
REQ-023 SHALL NOT reset RAM contents; RAM retains its values across reset.
REQ-024 SHALL ignore stores asserted during reset; the first store accepted is on the first rising edge with i_rst_n=1.
REQ-025 SHALL, when reset asserts mid-program, have counters restart from 0 on the first edge after release (CYCLE=1 after that edge).

Configuration
REQ-026 SHALL use macro DMEM_MMIO_EN; when defined, REQ-013..REQ-020 apply.
REQ-027 SHALL, without DMEM_MMIO_EN, map the full address space to RAM, tie o_tohost=0 and o_done=0, and omit the counters.

Verification
REQ-028 SHALL check: store 0xDEADBEEF to 0x010, load 0x010 next cycle -> rdata 0xDEADBEEF; same-cycle load returns the prior value.
REQ-029 SHALL check: release reset, read 0x7F0 after 10 edges -> 10; preload CYCLE near 0xFFFFFFFF via force -> wraps to 0.
REQ-030 SHALL check: 5 stores (3 RAM, 2 MMIO) -> STCNT read = 5; a store to 0x7F0 leaves CYCLE counting unaffected.
REQ-031 SHALL check: write 0x1 to 0x7F8 -> o_tohost=1, o_done=1 after the edge; write 0x1 to 0x7FC -> o_done=0, o_tohost stays 1.
REQ-032 SHALL check: assert i_rst_n low mid-cycle with o_done=1 -> o_done, o_tohost, and counters are 0 before the next edge, and a previously stored RAM word still reads back.
REQ-033 SHALL check with DMEM_MMIO_EN undefined: store 0xA5A5A5A5 to 0x7F8, load back -> 0xA5A5A5A5; o_done stays 0.
